// File: rtl/ma_output_decimator.sv
// ma_output_decimator
// Keeps every DECIM_FACTOR-th sample strobe from the moving-average filter and
// buffers kept samples in a first-word-fall-through FIFO that drains over a
// valid/ready interface. A kept sample that finds the FIFO full is dropped and
// raises a sticky overflow flag.
//
// Ports
//   clk             system clock, rising edge
//   reset_n         async active-low reset (release expected synchronous to clk)
//   ma_data_in      filter sample, sampled only when ma_data_valid=1
//   ma_data_valid   one-cycle sample strobe from the filter
//   dec_data_out    FIFO head sample (don't-care while dec_data_valid=0)
//   dec_data_valid  FIFO non-empty
//   dec_data_ready  consumer accepts the head this cycle
//   fifo_level      number of entries held, 0..FIFO_DEPTH
//   overflow        sticky: a kept sample was dropped
//   clear_overflow  synchronous clear of overflow (a same-cycle drop wins)
module ma_output_decimator #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned DECIM_FACTOR = 4,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_WIDTH-1:0]         ma_data_in,
  input  logic                          ma_data_valid,
  output logic [DATA_WIDTH-1:0]         dec_data_out,
  output logic                          dec_data_valid,
  input  logic                          dec_data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  // A one-bit phase counter is kept even for DECIM_FACTOR=1; it then sits at 0.
  localparam int unsigned PH_W  = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DECIM_FACTOR - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  logic [PH_W-1:0]       r_phase;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic w_keep;
  logic w_full;
  logic w_valid;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Keep/push/pop decode; a pop on a full FIFO frees the slot for a same-cycle push.
  always_comb begin
    w_keep  = ma_data_valid && (r_phase == PH_LAST);
    w_full  = (r_level == LVL_FULL);
    w_valid = (r_level != '0);
    w_pop   = w_valid && dec_data_ready;
    w_push  = w_keep && (!w_full || w_pop);
    w_drop  = w_keep && w_full && !w_pop;
  end

  // Decimation phase: advances on every strobe, independent of consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= '0;
    end else if (ma_data_valid) begin
      if (r_phase == PH_LAST) r_phase <= '0;
      else                    r_phase <= r_phase + PH_W'(1);
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of two).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sample storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= ma_data_in;
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign dec_data_out   = r_mem[r_rd_ptr];
  assign dec_data_valid = w_valid;
  assign fifo_level     = r_level;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_ma_output_decimator.sv
// Bench for ma_output_decimator: instance A uses DECIM_FACTOR=4, instance B
// uses DECIM_FACTOR=1; both have depth 8. Expected samples are queued by the
// stimulus and popped by per-instance monitors on each accepted handshake.
module tb_ma_output_decimator;

  logic        clk;
  logic        a_rst_n, b_rst_n;
  logic [15:0] a_md, b_md;
  logic        a_mv, b_mv;
  logic [15:0] a_out, b_out;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [3:0]  a_level, b_level;
  logic        a_ovf, b_ovf;
  logic        a_clr, b_clr;

  int checks;
  int failures;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  ma_output_decimator #(.DATA_WIDTH(16), .DECIM_FACTOR(4), .FIFO_DEPTH(8)) u_a (
    .clk(clk), .reset_n(a_rst_n), .ma_data_in(a_md), .ma_data_valid(a_mv),
    .dec_data_out(a_out), .dec_data_valid(a_valid), .dec_data_ready(a_ready),
    .fifo_level(a_level), .overflow(a_ovf), .clear_overflow(a_clr)
  );

  ma_output_decimator #(.DATA_WIDTH(16), .DECIM_FACTOR(1), .FIFO_DEPTH(8)) u_b (
    .clk(clk), .reset_n(b_rst_n), .ma_data_in(b_md), .ma_data_valid(b_mv),
    .dec_data_out(b_out), .dec_data_valid(b_valid), .dec_data_ready(b_ready),
    .fifo_level(b_level), .overflow(b_ovf), .clear_overflow(b_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change only just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor A
  always @(negedge clk) begin
    logic [15:0] e;
    if (a_rst_n && a_valid && a_ready) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_output actual=%0d required=none", a_out);
      end else begin
        e = qa.pop_front();
        chk("a_data", 32'(a_out), 32'(e));
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    logic [15:0] e;
    if (b_rst_n && b_valid && b_ready) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_output actual=%0d required=none", b_out);
      end else begin
        e = qb.pop_front();
        chk("b_data", 32'(b_out), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_md = '0; b_md = '0; a_mv = 1'b0; b_mv = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0; a_clr = 1'b0; b_clr = 1'b0;

    // 1: reset held while strobes toggle
    for (int i = 0; i < 6; i++) begin
      tick();
      a_mv = (i % 2 == 1); a_md = 16'(i + 1);
      b_mv = (i % 2 == 1); b_md = 16'(i + 1);
      @(negedge clk);
      chk("t1_a_valid", 32'(a_valid), 0);
      chk("t1_a_level", 32'(a_level), 0);
      chk("t1_a_ovf",   32'(a_ovf),   0);
      chk("t1_b_valid", 32'(b_valid), 0);
      chk("t1_b_level", 32'(b_level), 0);
      chk("t1_b_ovf",   32'(b_ovf),   0);
    end
    tick();
    a_mv = 1'b0; b_mv = 1'b0;
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // 2: D=4, consumer always ready; 4,8,12,16 come out, each valid one cycle
    a_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      a_mv = 1'b1; a_md = 16'(k);
      if (k % 4 == 0) qa.push_back(16'(k));
      tick();
      a_mv = 1'b0; a_md = 16'hDEAD;
      @(negedge clk);
      chk("t2_valid_latency", 32'(a_valid), 32'(k % 4 == 0));
    end
    tick();
    tick();
    chk("t2_level_empty", 32'(a_level), 0);

    // 3: D=1, stalled consumer, 9 strobes into depth 8
    for (int k = 0; k < 9; k++) begin
      tick();
      b_mv = 1'b1; b_md = 16'(100 + k);
      if (k < 8) qb.push_back(16'(100 + k));
      if (k == 8) begin
        @(negedge clk);
        chk("t3_level_full", 32'(b_level), 8);
        chk("t3_no_ovf_yet", 32'(b_ovf), 0);
      end
    end
    tick();
    b_mv = 1'b0;
    @(negedge clk);
    chk("t3_level_after_drop", 32'(b_level), 8);
    chk("t3_ovf_set", 32'(b_ovf), 1);
    chk("t3_head", 32'(b_out), 100);
    tick();
    b_ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("t3_drained_level", 32'(b_level), 0);
    chk("t3_drained_valid", 32'(b_valid), 0);
    chk("t3_ovf_sticky", 32'(b_ovf), 1);
    tick();
    b_ready = 1'b0; b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    @(negedge clk);
    chk("t3_ovf_cleared", 32'(b_ovf), 0);

    // 4: full FIFO, keep strobe coincides with a pop
    for (int k = 0; k < 8; k++) begin
      tick();
      b_mv = 1'b1; b_md = 16'(200 + k);
      qb.push_back(16'(200 + k));
    end
    tick();
    b_mv = 1'b1; b_md = 16'd208; b_ready = 1'b1;
    qb.push_back(16'd208);
    @(negedge clk);
    chk("t4_full_before", 32'(b_level), 8);
    tick();
    b_mv = 1'b0; b_ready = 1'b0;
    @(negedge clk);
    chk("t4_level", 32'(b_level), 8);
    chk("t4_no_ovf", 32'(b_ovf), 0);
    chk("t4_head_adv", 32'(b_out), 201);

    // 5: drop plus clear in the same cycle, then a clean clear
    tick();
    b_mv = 1'b1; b_md = 16'd209;
    tick();
    b_md = 16'd210; b_clr = 1'b1;
    @(negedge clk);
    chk("t5_set", 32'(b_ovf), 1);
    tick();
    b_mv = 1'b0;
    @(negedge clk);
    chk("t5_set_wins", 32'(b_ovf), 1);
    tick();
    b_clr = 1'b0;
    @(negedge clk);
    chk("t5_clean_clear", 32'(b_ovf), 0);
    chk("t5_level", 32'(b_level), 8);
    chk("t5_head_kept", 32'(b_out), 201);
    tick();
    b_ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("t5_drained", 32'(b_level), 0);
    tick();
    b_ready = 1'b0;

    // 6: reset mid-stream with level=5 and phase=2
    for (int k = 1; k <= 22; k++) begin
      tick();
      a_mv = 1'b1; a_md = 16'(1000 + k); a_ready = 1'b0;
    end
    tick();
    a_mv = 1'b0;
    @(negedge clk);
    chk("t6_level_pre", 32'(a_level), 5);
    tick();
    a_rst_n = 1'b0;
    #1;
    chk("t6_async_level", 32'(a_level), 0);
    chk("t6_async_valid", 32'(a_valid), 0);
    a_ready = 1'b1;
    tick();
    tick();
    a_rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      a_mv = 1'b1; a_md = 16'(2000 + k);
      if (k % 4 == 0) qa.push_back(16'(2000 + k));
      tick();
      a_mv = 1'b0; a_md = 16'hBEEF;
      @(negedge clk);
      chk("t6_valid_latency", 32'(a_valid), 32'(k % 4 == 0));
    end

    tick();
    tick();
    chk("a_queue_empty", 32'(qa.size()), 0);
    chk("b_queue_empty", 32'(qb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
